// File: rtl/joy_pkg.sv
// Shared constants for the serial joystick front-end: frame length, idle word,
// the slot-to-bit map of the external shift-register chain and button positions.
package joy_pkg;

    localparam int          JOY_SLOTS = 26;
    localparam logic [11:0] JOY_IDLE  = 12'hFFF;

    localparam int JB_RESET = 11;
    localparam int JB_START = 7;
    localparam int JB_COIN  = 6;

    // Which shadow word a slot feeds.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P1   = 2'd1,
        SEL_P2   = 2'd2
    } joy_sel_e;

    // Slots 0-1 carry nothing, then 8 player-1 bits, 8 player-2 bits,
    // the 4 upper player-2 bits and finally the 4 upper player-1 bits.
    localparam joy_sel_e JOY_SLOT_SEL [JOY_SLOTS] = '{
        SEL_NONE, SEL_NONE,
        SEL_P1, SEL_P1, SEL_P1, SEL_P1, SEL_P1, SEL_P1, SEL_P1, SEL_P1,
        SEL_P2, SEL_P2, SEL_P2, SEL_P2, SEL_P2, SEL_P2, SEL_P2, SEL_P2,
        SEL_P2, SEL_P2, SEL_P2, SEL_P2,
        SEL_P1, SEL_P1, SEL_P1, SEL_P1
    };

    localparam logic [3:0] JOY_SLOT_BIT [JOY_SLOTS] = '{
        4'd0,  4'd0,
        4'd8,  4'd6,  4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd8,  4'd6,  4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd10, 4'd11, 4'd9, 4'd7,
        4'd10, 4'd11, 4'd9, 4'd7
    };

endpackage

// File: rtl/joy_debounce.sv
// Frame-level debouncer: the output word only follows a new value after it has
// been seen in DEBOUNCE_FRAMES consecutive frames.
module joy_debounce #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int WIDTH           = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_frame,
    output logic [WIDTH-1:0] o_word
);

    localparam logic [2:0] CNT_MAX = 3'(DEBOUNCE_FRAMES);

    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_word;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_inc;

    assign w_cnt_inc = (r_cnt < CNT_MAX) ? (r_cnt + 3'd1) : CNT_MAX;
    assign o_word    = r_word;

    // Track agreement with the candidate and publish it once agreement is reached.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cand <= {WIDTH{1'b1}};
            r_word <= {WIDTH{1'b1}};
            r_cnt  <= CNT_MAX;
        end else if (i_valid) begin
            if (i_frame == r_cand) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_word <= r_cand;
                end
            end else begin
                r_cand <= i_frame;
                r_cnt  <= 3'd1;
                if (CNT_MAX == 3'd1) begin
                    r_word <= i_frame;
                end
            end
        end
    end

endmodule

// File: rtl/joy_serial_rx.sv
// Serial joystick front-end: clocks the external shift-register chain,
// deserialises 24 button bits per 26-slot frame and debounces both player words.
module joy_serial_rx
    import joy_pkg::*;
#(
    parameter int DIV_LOG2        = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_done
);

    localparam int             PW      = DIV_LOG2 + 1;
    // Last prescaler value of the low half; the next cycle raises joy_clk.
    localparam logic [PW-1:0]  RISE_AT = PW'((1 << DIV_LOG2) - 1);
    localparam logic [4:0]     LAST_SLOT = 5'(JOY_SLOTS - 1);

    logic [PW-1:0] r_pre;
    logic          r_sync0;
    logic          r_sync1;
    logic [4:0]    r_slot;
    logic          r_load;
    logic          r_frame_done;
    logic [11:0]   r_s1;
    logic [11:0]   r_s2;
    logic [11:0]   w_s1_next;
    logic [11:0]   w_s2_next;
    logic          w_rise;
    logic          w_last;

    assign w_rise     = (r_pre == RISE_AT);
    assign w_last     = w_rise && (r_slot == LAST_SLOT);
    assign joy_clk    = r_pre[PW-1];
    assign joy_load   = r_load;
    assign frame_done = r_frame_done;

    // Free-running prescaler and two-stage synchroniser for the chain data.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_pre   <= '0;
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_pre   <= r_pre + 1'b1;
            r_sync0 <= joy_data;
            r_sync1 <= r_sync0;
        end
    end

    // Shadow words with the current slot's bit merged in on a rise tick.
    always_comb begin
        w_s1_next = r_s1;
        w_s2_next = r_s2;
        if (w_rise) begin
            case (JOY_SLOT_SEL[r_slot])
                SEL_P1:  w_s1_next[JOY_SLOT_BIT[r_slot]] = r_sync1;
                SEL_P2:  w_s2_next[JOY_SLOT_BIT[r_slot]] = r_sync1;
                default: ;
            endcase
        end
    end

    // Slot sequencing, load strobe, shadow capture and end-of-frame pulse.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_slot       <= 5'd0;
            r_load       <= 1'b1;
            r_s1         <= JOY_IDLE;
            r_s2         <= JOY_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_rise) begin
                r_slot <= (r_slot == LAST_SLOT) ? 5'd0 : (r_slot + 5'd1);
                r_load <= (r_slot != 5'd0);
                r_s1   <= w_s1_next;
                r_s2   <= w_s2_next;
            end
        end
    end

    // Completed frames (including the slot-25 bit) feed the per-player debouncers;
    // bit 11 of each output goes to the reset / reboot logic untouched.
    joy_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .WIDTH           (12)
    ) u_deb1 (
        .i_clk   (clk12),
        .i_rst   (reset),
        .i_valid (w_last),
        .i_frame (w_s1_next),
        .o_word  (joystick1)
    );

    joy_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .WIDTH           (12)
    ) u_deb2 (
        .i_clk   (clk12),
        .i_rst   (reset),
        .i_valid (w_last),
        .i_frame (w_s2_next),
        .o_word  (joystick2)
    );

endmodule

// File: tb/tb_joy_serial_rx.sv
// Bench for joy_serial_rx: a chain model serialises per-frame words, expected
// debounced outputs are queued per frame and compared at each frame_done.
module tb_joy_serial_rx;

    typedef struct {
        logic [11:0] f1;
        logic [11:0] f2;
        logic [11:0] e1;
        logic [11:0] e2;
    } vec_t;

    typedef struct {
        logic [11:0] e1;
        logic [11:0] e2;
    } exp_t;

    localparam int NVA = 16;
    localparam int NVB = 5;

    logic        clk;
    logic        rst_a, rst_b;
    logic        jd_a, jd_b;
    logic        jclk_a, jclk_b, load_a, load_b, fd_a, fd_b;
    logic [11:0] j1_a, j2_a, j1_b, j2_b;

    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t va[NVA];
    vec_t vb[NVB];
    int   tcyc_a, tcyc_b;
    bit   drv_a_en;
    int   fbf_cnt = 0;

    joy_serial_rx #(.DIV_LOG2(4), .DEBOUNCE_FRAMES(2)) u_dut_a (
        .clk12(clk), .reset(rst_a), .joy_data(jd_a), .joy_clk(jclk_a),
        .joy_load(load_a), .joystick1(j1_a), .joystick2(j2_a), .frame_done(fd_a)
    );

    joy_serial_rx #(.DIV_LOG2(2), .DEBOUNCE_FRAMES(1)) u_dut_b (
        .clk12(clk), .reset(rst_b), .joy_data(jd_b), .joy_clk(jclk_b),
        .joy_load(load_b), .joystick1(j1_b), .joystick2(j2_b), .frame_done(fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles since reset release, one counter per instance.
    always @(posedge clk) begin
        if (rst_a) tcyc_a <= 0; else tcyc_a <= tcyc_a + 1;
        if (rst_b) tcyc_b <= 0; else tcyc_b <= tcyc_b + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit presented by the chain in a given slot for player words w1/w2.
    function automatic logic chain_bit(input logic [11:0] w1, input logic [11:0] w2, input int s);
        case (s)
            2:  return w1[8];   3:  return w1[6];   4:  return w1[5];   5:  return w1[4];
            6:  return w1[3];   7:  return w1[2];   8:  return w1[1];   9:  return w1[0];
            10: return w2[8];   11: return w2[6];   12: return w2[5];   13: return w2[4];
            14: return w2[3];   15: return w2[2];   16: return w2[1];   17: return w2[0];
            18: return w2[10];  19: return w2[11];  20: return w2[9];   21: return w2[7];
            22: return w1[10];  23: return w1[11];  24: return w1[9];   25: return w1[7];
            default: return 1'b1;
        endcase
    endfunction

    // Chain model for instance A (32-cycle slots), with glitches away from sampling.
    initial begin
        int g, f, s, last_g;
        logic b;
        exp_t e;
        last_g = -1;
        jd_a   = 1'b1;
        forever begin
            @(negedge clk);
            b = 1'b1;
            if (rst_a) begin
                last_g = -1;
            end else begin
                g = (tcyc_a + 8) / 32;
                f = g / 26;
                s = g % 26;
                if (drv_a_en && f < NVA) begin
                    if (g != last_g && s == 0) begin
                        e.e1 = va[f].e1;
                        e.e2 = va[f].e2;
                        qa.push_back(e);
                    end
                    b = chain_bit(va[f].f1, va[f].f2, s);
                    if ((tcyc_a % 32) inside {18, 19, 27, 28}) b = ~b;
                end
                last_g = g;
            end
            jd_a = b;
        end
    end

    // Chain model for instance B (8-cycle slots).
    initial begin
        int g, f, s, last_g;
        logic b;
        exp_t e;
        last_g = -1;
        jd_b   = 1'b1;
        forever begin
            @(negedge clk);
            b = 1'b1;
            if (rst_b) begin
                last_g = -1;
            end else begin
                g = (tcyc_b + 2) / 8;
                f = g / 26;
                s = g % 26;
                if (f < NVB) begin
                    if (g != last_g && s == 0) begin
                        e.e1 = vb[f].e1;
                        e.e2 = vb[f].e2;
                        qb.push_back(e);
                    end
                    b = chain_bit(vb[f].f1, vb[f].f2, s);
                end
                last_g = g;
            end
            jd_b = b;
        end
    end

    // Scoreboard for instance A.
    initial begin
        int nfd, lowc;
        exp_t e;
        nfd  = 0;
        lowc = 0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                nfd  = 0;
                lowc = 0;
            end else begin
                if (!load_a) lowc++;
                if (fd_a) begin
                    check("A frame_done cycle", tcyc_a, 816 + 832 * nfd);
                    check("A joy_load low cycles", lowc, 32);
                    check("A joy_clk at frame_done", {31'd0, jclk_a}, 1);
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL A unexpected frame_done at cycle %0d", tcyc_a);
                    end else begin
                        e = qa.pop_front();
                        check("A joystick1", {20'd0, j1_a}, {20'd0, e.e1});
                        check("A joystick2", {20'd0, j2_a}, {20'd0, e.e2});
                    end
                    nfd++;
                    lowc = 0;
                end
            end
        end
    end

    // Scoreboard for instance B.
    initial begin
        int nfd, lowc;
        exp_t e;
        nfd  = 0;
        lowc = 0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                nfd  = 0;
                lowc = 0;
            end else begin
                if (!load_b) lowc++;
                if (j1_b == 12'hFBF) fbf_cnt++;
                if (fd_b && nfd < NVB) begin
                    check("B frame_done cycle", tcyc_b, 204 + 208 * nfd);
                    check("B joy_load low cycles", lowc, 8);
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL B unexpected frame_done at cycle %0d", tcyc_b);
                    end else begin
                        e = qb.pop_front();
                        check("B joystick1", {20'd0, j1_b}, {20'd0, e.e1});
                        check("B joystick2", {20'd0, j2_b}, {20'd0, e.e2});
                    end
                end
                if (fd_b) begin
                    nfd++;
                    lowc = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        // Instance A: debounce depth 2. {frame1, frame2, expected1, expected2}
        va[0]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[1]  = '{12'hFEF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[2]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[3]  = '{12'hFEF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[4]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[5]  = '{12'hFEF, 12'hFFF, 12'hFFF, 12'hFFF};
        va[6]  = '{12'hFEF, 12'hFFF, 12'hFEF, 12'hFFF};
        va[7]  = '{12'hFFF, 12'h7FF, 12'hFEF, 12'hFFF};
        va[8]  = '{12'hFFF, 12'h7FF, 12'hFFF, 12'h7FF};
        va[9]  = '{12'h7FF, 12'hFFF, 12'hFFF, 12'h7FF};
        va[10] = '{12'h7FF, 12'hFFF, 12'h7FF, 12'hFFF};
        va[11] = '{12'h5A3, 12'hC3C, 12'h7FF, 12'hFFF};
        va[12] = '{12'h5A3, 12'hC3C, 12'h5A3, 12'hC3C};
        va[13] = '{12'hFFF, 12'h000, 12'h5A3, 12'hC3C};
        va[14] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        va[15] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        // Instance B: debounce depth 1, single-frame coin pulse.
        vb[0]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vb[1]  = '{12'hFBF, 12'hFFF, 12'hFBF, 12'hFFF};
        vb[2]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vb[3]  = '{12'hFFF, 12'h7FF, 12'hFFF, 12'h7FF};
        vb[4]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

        drv_a_en = 1'b1;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset joystick1", {20'd0, j1_a}, 32'hFFF);
        check("reset joystick2", {20'd0, j2_a}, 32'hFFF);
        check("reset joy_clk", {31'd0, jclk_a}, 0);
        check("reset joy_load", {31'd0, load_a}, 1);
        check("reset frame_done", {31'd0, fd_a}, 0);
        check("reset B joy_clk/load", {30'd0, jclk_b, load_b}, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Run instance A up to slot 13 of frame 15 (tick 403).
        for (int i = 0; i < 20000 && tcyc_a < 12912; i++) @(negedge clk);
        check("A frames consumed before reset", qa.size(), 1);
        check("A joystick2 low before reset", {20'd0, j2_a}, 32'h000);

        rst_a    = 1'b1;
        drv_a_en = 1'b0;
        @(negedge clk);
        check("mid-frame reset joystick1", {20'd0, j1_a}, 32'hFFF);
        check("mid-frame reset joystick2", {20'd0, j2_a}, 32'hFFF);
        check("mid-frame reset frame_done", {31'd0, fd_a}, 0);
        check("mid-frame reset joy_load", {31'd0, load_a}, 1);
        qa.delete();
        e.e1 = 12'hFFF;
        e.e2 = 12'hFFF;
        qa.push_back(e);
        @(negedge clk);
        rst_a = 1'b0;

        for (int i = 0; i < 2000 && qa.size() != 0; i++) @(negedge clk);
        check("A first frame after reset", qa.size(), 0);
        check("B frames consumed", qb.size(), 0);
        check("B coin pulse length", fbf_cnt, 208);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
